// File: rtl/vp_gfx_serializer.sv
// ---------------------------------------------------------------------------
// vp_gfx_serializer
//   Consumer end of the vp_gfx_bitmap interface. Each enable strobe delivers
//   one cell row (bitmap plus foreground/background colour). The row is
//   double-buffered: a holding register and a shift register. One colour
//   index is emitted per pixel_tick, leftmost pixel (bitmap MSB) first.
//   Back-to-back cells stream with no gap pixel.
//
// Ports
//   clk            in   pipeline clock
//   reset          in   asynchronous, active-low reset
//   gfx_bitmap     in   cell row, bit WIDTH-1 = leftmost pixel
//   gfx_foreground in   colour for 1 bits
//   gfx_background in   colour for 0 bits
//   enable         in   load strobe, one cycle per cell row
//   pixel_tick     in   advance one pixel
//   ready          out  holding register empty; a load is accepted this cycle
//   pixel_color    out  colour of the current pixel (registered)
//   pixel_valid    out  pixel_color is meaningful (registered)
//   underrun       out  1-cycle pulse: last pixel consumed, no next cell
//   overflow       out  1-cycle pulse: enable while full, cell dropped
//   dbg_state_o    out  FSM state (0 = IDLE, 1 = RUN)
//   dbg_count_o    out  current pixel index within the shifter
//
// Handshake: a cell is accepted on any cycle where enable=1 and either the
// shifter is idle, the holding register is empty (ready=1), or the holding
// register is freed in that same cycle by the last-pixel tick. An enable in
// any other cycle drops the cell and pulses overflow. ready depends only on
// the holding-full flop, never combinationally on enable.
// ---------------------------------------------------------------------------
module vp_gfx_serializer #(
  parameter int WIDTH      = 16,
  parameter int COLOR_BITS = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           gfx_bitmap,
  input  logic [COLOR_BITS-1:0]      gfx_foreground,
  input  logic [COLOR_BITS-1:0]      gfx_background,
  input  logic                       enable,
  input  logic                       pixel_tick,
  output logic                       ready,
  output logic [COLOR_BITS-1:0]      pixel_color,
  output logic                       pixel_valid,
  output logic                       underrun,
  output logic                       overflow,
  output logic                       dbg_state_o,
  output logic [$clog2(WIDTH)-1:0]   dbg_count_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [WIDTH-1:0]      shift_q, shift_d;
  logic [COLOR_BITS-1:0] sh_fg_q, sh_fg_d;
  logic [COLOR_BITS-1:0] sh_bg_q, sh_bg_d;
  logic [WIDTH-1:0]      hold_q, hold_d;
  logic [COLOR_BITS-1:0] hold_fg_q, hold_fg_d;
  logic [COLOR_BITS-1:0] hold_bg_q, hold_bg_d;
  logic                  hold_full_q, hold_full_d;
  logic [COLOR_BITS-1:0] color_q, color_d;
  logic                  valid_q, valid_d;
  logic                  underrun_q, underrun_d;
  logic                  overflow_q, overflow_d;
  logic                  last_tick;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    shift_d     = shift_q;
    sh_fg_d     = sh_fg_q;
    sh_bg_d     = sh_bg_q;
    hold_d      = hold_q;
    hold_fg_d   = hold_fg_q;
    hold_bg_d   = hold_bg_q;
    hold_full_d = hold_full_q;
    underrun_d  = 1'b0;
    overflow_d  = 1'b0;
    last_tick   = (state_q == S_RUN) && pixel_tick && (count_q == LAST);

    case (state_q)
      S_IDLE: begin
        // pixel_tick is ignored here; the holding register is always empty.
        if (enable) begin
          shift_d = gfx_bitmap;
          sh_fg_d = gfx_foreground;
          sh_bg_d = gfx_background;
          count_d = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (pixel_tick) begin
          if (count_q != LAST) begin
            // The shifter moves left so the current pixel is always the MSB.
            count_d = count_q + 1'b1;
            shift_d = {shift_q[WIDTH-2:0], 1'b0};
          end else if (hold_full_q) begin
            shift_d     = hold_q;
            sh_fg_d     = hold_fg_q;
            sh_bg_d     = hold_bg_q;
            count_d     = '0;
            hold_full_d = 1'b0;
          end else if (enable) begin
            // New cell bypasses the holding register: no gap pixel.
            shift_d = gfx_bitmap;
            sh_fg_d = gfx_foreground;
            sh_bg_d = gfx_background;
            count_d = '0;
          end else begin
            state_d    = S_IDLE;
            count_d    = '0;
            underrun_d = 1'b1;
          end
        end

        if (enable) begin
          if (last_tick && !hold_full_q) begin
            // Already taken straight into the shifter above.
          end else if (!hold_full_q || last_tick) begin
            // Holding is empty, or freed by this cycle's last-pixel tick.
            hold_d      = gfx_bitmap;
            hold_fg_d   = gfx_foreground;
            hold_bg_d   = gfx_background;
            hold_full_d = 1'b1;
          end else begin
            overflow_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Output register is fed from next state so the first pixel shows one
    // cycle after the load, and each new pixel one cycle after its tick.
    valid_d = (state_d == S_RUN);
    if (state_d == S_RUN) begin
      color_d = shift_d[WIDTH-1] ? sh_fg_d : sh_bg_d;
    end else begin
      color_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      shift_q     <= '0;
      sh_fg_q     <= '0;
      sh_bg_q     <= '0;
      hold_q      <= '0;
      hold_fg_q   <= '0;
      hold_bg_q   <= '0;
      hold_full_q <= 1'b0;
      color_q     <= '0;
      valid_q     <= 1'b0;
      underrun_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      shift_q     <= shift_d;
      sh_fg_q     <= sh_fg_d;
      sh_bg_q     <= sh_bg_d;
      hold_q      <= hold_d;
      hold_fg_q   <= hold_fg_d;
      hold_bg_q   <= hold_bg_d;
      hold_full_q <= hold_full_d;
      color_q     <= color_d;
      valid_q     <= valid_d;
      underrun_q  <= underrun_d;
      overflow_q  <= overflow_d;
    end
  end

  assign ready       = ~hold_full_q;
  assign pixel_color = color_q;
  assign pixel_valid = valid_q;
  assign underrun    = underrun_q;
  assign overflow    = overflow_q;
  assign dbg_state_o = state_q;
  assign dbg_count_o = count_q;

endmodule

// File: tb/tb_vp_gfx_serializer.sv
module tb_vp_gfx_serializer;

  logic        clk;
  logic        reset;
  logic [15:0] gfx_bitmap;
  logic [3:0]  gfx_foreground;
  logic [3:0]  gfx_background;
  logic        enable;
  logic        pixel_tick;
  logic        ready;
  logic [3:0]  pixel_color;
  logic        pixel_valid;
  logic        underrun;
  logic        overflow;
  logic        dbg_state_o;
  logic [3:0]  dbg_count_o;

  vp_gfx_serializer #(.WIDTH(16), .COLOR_BITS(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .gfx_bitmap     (gfx_bitmap),
    .gfx_foreground (gfx_foreground),
    .gfx_background (gfx_background),
    .enable         (enable),
    .pixel_tick     (pixel_tick),
    .ready          (ready),
    .pixel_color    (pixel_color),
    .pixel_valid    (pixel_valid),
    .underrun       (underrun),
    .overflow       (overflow),
    .dbg_state_o    (dbg_state_o),
    .dbg_count_o    (dbg_count_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  typedef struct {
    int          at;
    logic [15:0] bm;
    logic [3:0]  fg;
    logic [3:0]  bg;
  } inj_t;

  logic [3:0] exp_q[$];
  inj_t       inj_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_run(input logic [3:0] colour, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(colour);
  endtask

  task automatic add_inj(input int at, input logic [15:0] bm, input logic [3:0] fg,
                         input logic [3:0] bg);
    inj_t e;
    e.at = at; e.bm = bm; e.fg = fg; e.bg = bg;
    inj_q.push_back(e);
  endtask

  task automatic start_cell(input logic [15:0] bm, input logic [3:0] fg, input logic [3:0] bg);
    gfx_bitmap     = bm;
    gfx_foreground = fg;
    gfx_background = bg;
    enable         = 1'b1;
    pixel_tick     = 1'b1;
    step();
  endtask

  // Checks n displayed cycles against exp_q. In iteration c the inputs for
  // the next edge are driven: ticks every 'period' cycles, queued loads at
  // their index, scrambled inputs otherwise (buffered cells must not change).
  task automatic run_pixels(input int n, input int period, input int ovf_at, input int rdy_low_at);
    logic [3:0] e;
    for (int c = 0; c < n; c++) begin
      check("valid", pixel_valid, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("colour[%0d]", c), pixel_color, e);
      end else begin
        check("exp_q_empty", 1, 0);
      end
      check($sformatf("count[%0d]", c), dbg_count_o, (c / period) % 16);
      check("underrun_mid", underrun, 0);
      check($sformatf("overflow[%0d]", c), overflow, (c == ovf_at) ? 1 : 0);
      if (c == rdy_low_at) check("ready_low", ready, 0);
      pixel_tick = ((c + 1) % period) == 0;
      if (inj_q.size() > 0 && inj_q[0].at == c) begin
        gfx_bitmap     = inj_q[0].bm;
        gfx_foreground = inj_q[0].fg;
        gfx_background = inj_q[0].bg;
        enable         = 1'b1;
        void'(inj_q.pop_front());
      end else begin
        enable         = 1'b0;
        gfx_bitmap     = 16'($urandom);
        gfx_foreground = 4'($urandom_range(15, 0));
        gfx_background = 4'($urandom_range(15, 0));
      end
      step();
    end
    enable     = 1'b0;
    pixel_tick = 1'b0;
  endtask

  task automatic end_check(input string tag);
    check({tag, "_valid0"}, pixel_valid, 0);
    check({tag, "_colour0"}, pixel_color, 0);
    check({tag, "_underrun"}, underrun, 1);
    check({tag, "_idle"}, dbg_state_o, 0);
    check({tag, "_ready"}, ready, 1);
    step();
    check({tag, "_underrun_off"}, underrun, 0);
    check({tag, "_exp_q_drained"}, exp_q.size(), 0);
  endtask

  int t2[16] = '{1, 2, 1, 2, 2, 1, 2, 1, 2, 2, 2, 2, 1, 1, 1, 1};

  initial begin
    reset          = 1'b0;
    gfx_bitmap     = '0;
    gfx_foreground = '0;
    gfx_background = '0;
    enable         = 1'b0;
    pixel_tick     = 1'b0;
    step();
    step();
    check("rst_ready", ready, 1);
    check("rst_valid", pixel_valid, 0);
    check("rst_colour", pixel_color, 0);
    check("rst_underrun", underrun, 0);
    check("rst_overflow", overflow, 0);
    check("rst_state", dbg_state_o, 0);
    check("rst_count", dbg_count_o, 0);
    reset = 1'b1;
    step();

    // tick in IDLE is ignored, no underrun
    pixel_tick = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle_tick_valid", pixel_valid, 0);
      check("idle_tick_underrun", underrun, 0);
    end
    pixel_tick = 1'b0;

    // Test 2: A50F, fg=1 bg=2, tick every cycle
    foreach (t2[i]) exp_q.push_back(4'(t2[i]));
    start_cell(16'hA50F, 4'd1, 4'd2);
    run_pixels(16, 1, -1, -1);
    end_check("t2");

    // Test 3: FFFF fg=3 then 0000 bg=4 loaded during A, seamless
    push_run(4'd3, 16);
    push_run(4'd4, 16);
    add_inj(0, 16'h0000, 4'd7, 4'd4);
    start_cell(16'hFFFF, 4'd3, 4'd9);
    run_pixels(32, 1, -1, 1);
    end_check("t3");

    // Test 4: A, B held, C while full and not at last pixel -> dropped
    push_run(4'd1, 4);
    push_run(4'd2, 12);
    push_run(4'd4, 8);
    push_run(4'd3, 8);
    add_inj(0, 16'h00FF, 4'd3, 4'd4);
    add_inj(1, 16'hFFFF, 4'd5, 4'd5);
    start_cell(16'hF000, 4'd1, 4'd2);
    run_pixels(32, 1, 2, 1);
    end_check("t4");

    // Test 5: tick every 3rd cycle, 8001 fg=5 bg=6
    push_run(4'd5, 3);
    push_run(4'd6, 42);
    push_run(4'd5, 3);
    start_cell(16'h8001, 4'd5, 4'd6);
    run_pixels(48, 3, -1, -1);
    end_check("t5");

    // Test 6: enable coincides with last-pixel tick, holding empty
    push_run(4'd8, 15);
    push_run(4'd7, 1);
    push_run(4'd9, 1);
    push_run(4'd10, 15);
    add_inj(15, 16'h8000, 4'd9, 4'd10);
    start_cell(16'h0001, 4'd7, 4'd8);
    run_pixels(32, 1, -1, -1);
    end_check("t6");

    // enable with holding full at the last-pixel tick -> accepted, no overflow
    push_run(4'd1, 16);
    push_run(4'd2, 16);
    push_run(4'd3, 16);
    add_inj(0, 16'h0000, 4'd0, 4'd2);
    add_inj(15, 16'hFFFF, 4'd3, 4'd0);
    start_cell(16'hFFFF, 4'd1, 4'd0);
    run_pixels(48, 1, -1, 16);
    end_check("t7");

    // Test 1: reset mid-RUN with a cell held
    gfx_bitmap = 16'hFFFF; gfx_foreground = 4'd3; gfx_background = 4'd0;
    enable = 1'b1; pixel_tick = 1'b1;
    step();
    step();
    enable = 1'b0;
    step();
    check("t1_pre_valid", pixel_valid, 1);
    check("t1_pre_ready", ready, 0);
    reset = 1'b0;
    #1;
    check("t1_async_valid", pixel_valid, 0);
    check("t1_async_ready", ready, 1);
    step();
    check("t1_valid", pixel_valid, 0);
    check("t1_ready", ready, 1);
    check("t1_colour", pixel_color, 0);
    check("t1_state", dbg_state_o, 0);
    reset = 1'b1;
    pixel_tick = 1'b0;
    step();
    push_run(4'd11, 1);
    push_run(4'd12, 15);
    start_cell(16'h8000, 4'd11, 4'd12);
    run_pixels(16, 1, -1, -1);
    end_check("t1");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
